// File: rtl/lr35902_lcd_fb.sv
// PPU frame capture: packs 2-bit pixels four per byte, buffers them in a FIFO and
// writes them to a 160x144 framebuffer over a req/ack port.
module lr35902_lcd_fb #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_on,
  input  logic        px_out,
  input  logic [1:0]  px,
  output logic        fb_req,
  output logic [12:0] fb_adr,
  output logic [7:0]  fb_dat,
  input  logic        fb_ack,
  output logic        frame_done,
  output logic        overflow,
  input  logic        ov_clr
);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned EW     = 21;
  localparam logic [7:0]  X_LAST = 8'd159;
  localparam logic [7:0]  Y_LAST = 8'd143;

  typedef enum logic {ST_IDLE, ST_CAPTURE} state_e;

  state_e         state_q, state_d;
  logic [7:0]     x_q, x_d, y_q, y_d;
  logic [12:0]    adr_q, adr_d;
  logic [7:0]     part_q, part_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_pop;
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [EW-1:0]  push_ent, head_d;
  logic [7:0]     slot;
  logic           push, pop, full, accept, drop, frame_end;
  logic           req_q, req_d, fd_q, fd_d, ovf_q, ovf_d;
  logic [12:0]    oadr_q;
  logic [7:0]     odat_q;

  assign fb_req     = req_q;
  assign fb_adr     = oadr_q;
  assign fb_dat     = odat_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

  // Capture state, position counters, packing and FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    adr_d     = adr_q;
    part_d    = part_q;
    slot      = part_q;
    push      = 1'b0;
    push_ent  = {adr_q, part_q};
    fd_d      = 1'b0;
    frame_end = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      ST_IDLE:    if (disp_on)  state_d = ST_CAPTURE;
      ST_CAPTURE: if (!disp_on) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      x_d    = '0;
      y_d    = '0;
      adr_d  = '0;
      part_d = '0;
    end else if (px_out) begin
      case (x_q[1:0])
        2'd0:    slot[7:6] = px;
        2'd1:    slot[5:4] = px;
        2'd2:    slot[3:2] = px;
        default: slot[1:0] = px;
      endcase
      part_d = slot;
      if (x_q[1:0] == 2'd3) begin
        push     = 1'b1;
        push_ent = {adr_q, slot};
        adr_d    = frame_end ? 13'd0 : adr_q + 13'd1;
      end
      if (x_q == X_LAST) begin
        x_d = 8'd0;
        y_d = (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
      fd_d = frame_end;
    end

    pop     = req_q & fb_ack;
    full    = (cnt_q == CW'(FIFO_DEPTH));
    accept  = push & (~full | pop);
    drop    = push & ~accept;
    cnt_pop = cnt_q - CW'(pop);
    wr_d    = accept ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_pop + CW'(accept);
    req_d   = (cnt_d != '0);
    // A byte pushed into an empty (or just-drained) FIFO bypasses the memory read
    head_d  = (accept && cnt_pop == '0) ? push_ent : mem_q[rd_d];
    ovf_d   = drop ? 1'b1 : (ov_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      adr_q   <= '0;
      part_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      oadr_q  <= '0;
      odat_q  <= '0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      adr_q   <= adr_d;
      part_q  <= part_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      oadr_q  <= head_d[20:8];
      odat_q  <= head_d[7:0];
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= push_ent;
  end
endmodule

// File: tb/tb_lr35902_lcd_fb.sv
// Bench for lr35902_lcd_fb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lr35902_lcd_fb;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        disp_on = 1'b0, px_out = 1'b0, fb_ack = 1'b0, ov_clr = 1'b0;
  logic [1:0]  px = 2'd0;
  logic        fb_req, frame_done, overflow;
  logic [12:0] fb_adr;
  logic [7:0]  fb_dat;

  int checks = 0, errors = 0;
  int req_cycles = 0, fd_cnt = 0;
  logic [20:0] wlog[$];

  lr35902_lcd_fb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .disp_on(disp_on), .px_out(px_out), .px(px),
    .fb_req(fb_req), .fb_adr(fb_adr), .fb_dat(fb_dat), .fb_ack(fb_ack),
    .frame_done(frame_done), .overflow(overflow), .ov_clr(ov_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel index within the frame, address from y*40 + x/4
  logic [20:0] mq[$];
  int          mpix = 0;
  logic [7:0]  mpart = 8'd0;
  bit          movf = 0, mfd = 0;

  always @(posedge clk or negedge reset) begin
    bit          pop, drop, have;
    int          x, y;
    logic [20:0] ent;
    if (!reset) begin
      mq.delete();
      mpix = 0; mpart = 8'd0; movf = 0; mfd = 0;
    end else begin
      pop = (mq.size() != 0) && fb_ack;
      have = 0; drop = 0; mfd = 0; ent = '0;
      if (!disp_on) begin
        mpix = 0; mpart = 8'd0;
      end else if (px_out) begin
        x = mpix % 160;
        y = mpix / 160;
        mpart[7 - 2*(x % 4) -: 2] = px;
        if (x % 4 == 3) begin
          ent = {13'(y*40 + x/4), mpart};
          have = 1;
        end
        if (mpix == 160*144 - 1) begin mfd = 1; mpix = 0; end
        else mpix++;
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(ent);
        else drop = 1;
      end
      if (drop) movf = 1;
      else if (ov_clr) movf = 0;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    chk("fb_req", 32'(fb_req), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("fb_adr", 32'(fb_adr), 32'(mq[0][20:8]));
      chk("fb_dat", 32'(fb_dat), 32'(mq[0][7:0]));
    end
    chk("frame_done", 32'(frame_done), 32'(mfd));
    chk("overflow", 32'(overflow), 32'(movf));
    if (fb_req) req_cycles++;
    if (frame_done) fd_cnt++;
  end

  // Log of writes accepted by the memory
  always @(posedge clk) begin
    if (reset && fb_req && fb_ack) wlog.push_back({fb_adr, fb_dat});
  end

  task automatic pix(input logic [1:0] v);
    @(negedge clk); disp_on = 1'b1; px_out = 1'b1; px = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); px_out = 1'b0; end
  endtask

  task automatic disp_cycle;
    @(negedge clk); disp_on = 1'b0; px_out = 1'b0;
    @(negedge clk); disp_on = 1'b1;
  endtask

  initial begin
    int bad;
    // Reset state
    #3;
    chk("rst_req", 32'(fb_req), 0);
    chk("rst_adr", 32'(fb_adr), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk); reset = 1'b1;
    req_cycles = 0;

    // Single byte: 3,2,1,0 -> 0xE4 at address 0, one request cycle
    fb_ack = 1'b1;
    pix(2'd3); pix(2'd2); pix(2'd1); pix(2'd0);
    idle(4);
    chk("t1_writes", 32'(wlog.size()), 1);
    if (wlog.size() > 0) chk("t1_entry", 32'(wlog[0]), 32'({13'd0, 8'hE4}));
    chk("t1_req_cycles", 32'(req_cycles), 1);

    // Full frame of px=1
    disp_cycle();
    wlog.delete(); fd_cnt = 0;
    repeat (160*144) pix(2'd1);
    idle(4);
    chk("frame_writes", 32'(wlog.size()), 5760);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] != {13'(i), 8'h55}) bad++;
    chk("frame_order", 32'(bad), 0);
    chk("frame_done_cnt", 32'(fd_cnt), 1);
    wlog.delete();
    pix(2'd2); pix(2'd2); pix(2'd2); pix(2'd2);
    idle(3);
    if (wlog.size() > 0) chk("next_frame", 32'(wlog[0]), 32'({13'd0, 8'hAA}));
    else chk("next_frame_cnt", 0, 1);

    // Overflow with the write port stalled
    disp_cycle();
    wlog.delete(); fb_ack = 1'b0;
    repeat (40) pix(2'd3);
    idle(2);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head", 32'(fb_adr), 0);
    fb_ack = 1'b1;
    idle(12);
    chk("ovf_writes", 32'(wlog.size()), 8);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i][20:8] != 13'(i)) bad++;
    chk("ovf_order", 32'(bad), 0);
    wlog.delete();
    pix(2'd0); pix(2'd1); pix(2'd2); pix(2'd3);
    idle(3);
    if (wlog.size() > 0) chk("ovf_resume", 32'(wlog[0]), 32'({13'd10, 8'h1B}));
    else chk("ovf_resume_cnt", 0, 1);
    @(negedge clk); ov_clr = 1'b1;
    @(negedge clk); ov_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    // Drop and clear on the same edge: set wins
    fb_ack = 1'b0;
    repeat (35) pix(2'd1);
    pix(2'd1); ov_clr = 1'b1;
    @(negedge clk); ov_clr = 1'b0; px_out = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 1);
    fb_ack = 1'b1;
    idle(12);
    @(negedge clk); ov_clr = 1'b1;
    @(negedge clk); ov_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);

    // Display drop mid-line discards the partial byte
    disp_cycle();
    wlog.delete();
    repeat (6) pix(2'd1);
    @(negedge clk); disp_on = 1'b0; px_out = 1'b0;
    idle(3);
    pix(2'd2); pix(2'd2); pix(2'd2); pix(2'd2);
    idle(3);
    chk("doff_writes", 32'(wlog.size()), 2);
    if (wlog.size() == 2) begin
      chk("doff_w0", 32'(wlog[0]), 32'({13'd0, 8'h55}));
      chk("doff_w1", 32'(wlog[1]), 32'({13'd0, 8'hAA}));
    end

    // Random acknowledge over two lines
    disp_cycle();
    wlog.delete();
    for (int i = 0; i < 320; i++) begin
      pix(2'($urandom_range(0, 3)));
      fb_ack = 1'($urandom_range(0, 1));
    end
    fb_ack = 1'b1;
    idle(12);
    chk("rand_writes", 32'(wlog.size()), 80);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i][20:8] != 13'(i)) bad++;
    chk("rand_order", 32'(bad), 0);

    // Asynchronous reset with a pending write
    disp_cycle();
    fb_ack = 1'b0;
    repeat (8) pix(2'd3);
    idle(1);
    chk("pre_rst_req", 32'(fb_req), 1);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("arst_req", 32'(fb_req), 0);
    chk("arst_adr", 32'(fb_adr), 0);
    chk("arst_dat", 32'(fb_dat), 0);
    chk("arst_fd", 32'(frame_done), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(negedge clk); reset = 1'b1;
    wlog.delete(); fb_ack = 1'b1;
    pix(2'd3); pix(2'd3); pix(2'd3); pix(2'd3);
    idle(3);
    chk("post_rst_writes", 32'(wlog.size()), 1);
    if (wlog.size() > 0) chk("post_rst_entry", 32'(wlog[0]), 32'({13'd0, 8'hFF}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
